// File: rtl/fp_mul_result_queue_if.sv
// Beat-level bus between the FP32 multiplier, the result queue and its consumer.
// The queue uses the slave view; the producer/consumer side uses master.
interface fp_mul_result_queue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] fp_Z;
    logic        ovrf;
    logic        udrf;
    logic [2:0]  r_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_z;
    logic        out_ovrf;
    logic        out_udrf;
    logic [2:0]  out_rmode;
    logic [2:0]  out_class;

    modport slave (
        input  in_valid, fp_Z, ovrf, udrf, r_mode, out_ready,
        output in_ready, out_valid, out_z, out_ovrf, out_udrf, out_rmode, out_class
    );

    modport master (
        output in_valid, fp_Z, ovrf, udrf, r_mode, out_ready,
        input  in_ready, out_valid, out_z, out_ovrf, out_udrf, out_rmode, out_class
    );
endinterface

// File: rtl/fp_mul_result_queue.sv
// Result queue behind the FP32 multiplier: classifies each product, buffers it in a
// DEPTH-entry FIFO with valid/ready output, and tracks overflow/underflow statistics.
module fp_mul_result_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    fp_mul_result_queue_if.slave   bus,
    output logic [$clog2(DEPTH):0] count,
    output logic [CNT_W-1:0]       ovf_cnt,
    output logic [CNT_W-1:0]       udf_cnt,
    output logic                   flag_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] C_NORM   = 3'd0;
    localparam logic [2:0] C_ZERO   = 3'd1;
    localparam logic [2:0] C_DENORM = 3'd2;
    localparam logic [2:0] C_INF    = 3'd3;
    localparam logic [2:0] C_QNAN   = 3'd4;
    localparam logic [2:0] C_SNAN   = 3'd5;

    typedef struct packed {
        logic [31:0] z;
        logic        ovrf;
        logic        udrf;
        logic [2:0]  rmode;
        logic [2:0]  cls;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] ovf_q, ovf_d;
    logic [CNT_W-1:0] udf_q, udf_d;
    logic             err_q, err_d;
    logic             push, pop;
    entry_t           head, beat;

    function automatic logic [2:0] classify(input logic [7:0] e, input logic [22:0] m);
        if (e == 8'h00) return (m == '0) ? C_ZERO : C_DENORM;
        if (e == 8'hFF) begin
            if (m == '0) return C_INF;
            return m[22] ? C_QNAN : C_SNAN;
        end
        return C_NORM;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Flags that cannot both be true of a single product, or contradict its exponent.
    function automatic logic flag_conflict(input logic ov, input logic ud, input logic [7:0] e);
        return (ov & ud) | (ov & (e == 8'h00)) | (ud & (e == 8'hFF));
    endfunction

    assign bus.in_ready  = (count_q < CW'(DEPTH));
    assign bus.out_valid = (count_q != '0);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    assign head          = mem_q[rd_ptr_q];
    assign bus.out_z     = head.z;
    assign bus.out_ovrf  = head.ovrf;
    assign bus.out_udrf  = head.udrf;
    assign bus.out_rmode = head.rmode;
    assign bus.out_class = head.cls;

    assign count    = count_q;
    assign ovf_cnt  = ovf_q;
    assign udf_cnt  = udf_q;
    assign flag_err = err_q;

    always_comb begin
        beat.z     = bus.fp_Z;
        beat.ovrf  = bus.ovrf;
        beat.udrf  = bus.udrf;
        beat.rmode = bus.r_mode;
        beat.cls   = classify(bus.fp_Z[30:23], bus.fp_Z[22:0]);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        err_d    = err_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (bus.ovrf) ovf_d = sat_inc(ovf_q);
            if (bus.udrf) udf_d = sat_inc(udf_q);
            if (flag_conflict(bus.ovrf, bus.udrf, bus.fp_Z[30:23])) err_d = 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= beat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
            udf_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_fp_mul_result_queue.sv
// Bench for fp_mul_result_queue: table-driven class/flag vectors, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_fp_mul_result_queue;
    localparam int DEPTH = 8;
    localparam int MAXC  = 65535;

    logic        clk;
    logic        rst;
    logic        rst2;
    logic [3:0]  count;
    logic [15:0] ovf_cnt, udf_cnt;
    logic        flag_err;
    logic [3:0]  count2;
    logic [1:0]  ovf_cnt2, udf_cnt2;
    logic        flag_err2;

    fp_mul_result_queue_if bus ();
    fp_mul_result_queue_if bus2 ();

    fp_mul_result_queue #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .count(count), .ovf_cnt(ovf_cnt), .udf_cnt(udf_cnt), .flag_err(flag_err)
    );

    fp_mul_result_queue #(.DEPTH(DEPTH), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst2), .bus(bus2.slave),
        .count(count2), .ovf_cnt(ovf_cnt2), .udf_cnt(udf_cnt2), .flag_err(flag_err2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] z;
        logic        ov;
        logic        ud;
        logic [2:0]  rm;
    } beat_t;

    typedef struct {
        logic [31:0] z;
        logic        ov;
        logic        ud;
        logic [2:0]  rm;
        logic [2:0]  exp_class;
        logic        exp_err;
    } vec_t;

    beat_t mq[$];
    int    ovf_m, udf_m;
    bit    err_m;
    int    checks = 0;
    int    failures = 0;
    vec_t  vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] ref_class(input logic [31:0] z);
        int e, m;
        e = int'(z[30:23]);
        m = int'(z[22:0]);
        if (e == 0) return (m == 0) ? 3'd1 : 3'd2;
        if (e == 255) begin
            if (m == 0) return 3'd3;
            if (m >= 32'h0040_0000) return 3'd4;
            return 3'd5;
        end
        return 3'd0;
    endfunction

    task automatic check_state();
        beat_t h;
        chk("count", 32'(count), 32'(mq.size()));
        chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
        chk("ovf_cnt", 32'(ovf_cnt), 32'(ovf_m));
        chk("udf_cnt", 32'(udf_cnt), 32'(udf_m));
        chk("flag_err", 32'(flag_err), 32'(err_m));
        if (mq.size() != 0) begin
            h = mq[0];
            chk("out_z", bus.out_z, h.z);
            chk("out_ovrf", 32'(bus.out_ovrf), 32'(h.ov));
            chk("out_udrf", 32'(bus.out_udrf), 32'(h.ud));
            chk("out_rmode", 32'(bus.out_rmode), 32'(h.rm));
            chk("out_class", 32'(bus.out_class), 32'(ref_class(h.z)));
        end
    endtask

    task automatic cycle(input logic iv, input logic [31:0] z, input logic ov, input logic ud,
                         input logic [2:0] rm, input logic ordy);
        bit    do_push, do_pop;
        int    e;
        beat_t b;
        bus.in_valid  = iv;
        bus.fp_Z      = z;
        bus.ovrf      = ov;
        bus.udrf      = ud;
        bus.r_mode    = rm;
        bus.out_ready = ordy;
        do_push = iv && (mq.size() < DEPTH);
        do_pop  = ordy && (mq.size() != 0);
        chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
        @(posedge clk);
        #1;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            b.z = z; b.ov = ov; b.ud = ud; b.rm = rm;
            mq.push_back(b);
            e = int'(z[30:23]);
            if (ov && ovf_m < MAXC) ovf_m++;
            if (ud && udf_m < MAXC) udf_m++;
            if ((ov && ud) || (ov && e == 0) || (ud && e == 255)) err_m = 1'b1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check_state();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        ovf_m = 0;
        udf_m = 0;
        err_m = 1'b0;
        check_state();
    endtask

    function automatic logic [31:0] rand_z();
        logic [31:0] s;
        logic [31:0] m;
        s = 32'($urandom_range(0, 1)) << 31;
        m = $urandom & 32'h007F_FFFF;
        case ($urandom_range(0, 6))
            0:       return s;
            1:       return s | (m == 0 ? 32'd1 : m);
            2:       return s | 32'h7F80_0000;
            3:       return s | 32'h7FC0_0000 | m;
            4:       return s | 32'h7F80_0000 | ((m & 32'h003F_FFFF) == 0 ? 32'd5 : (m & 32'h003F_FFFF));
            default: return s | (32'($urandom_range(1, 254)) << 23) | m;
        endcase
    endfunction

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        rst2 = 1'b1;
        bus.in_valid = 1'b0; bus.fp_Z = '0; bus.ovrf = 1'b0; bus.udrf = 1'b0;
        bus.r_mode = '0; bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.fp_Z = '0; bus2.ovrf = 1'b0; bus2.udrf = 1'b0;
        bus2.r_mode = '0; bus2.out_ready = 1'b0;

        vecs[0]  = '{32'h3F80_0000, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0};
        vecs[1]  = '{32'h7F80_0000, 1'b1, 1'b0, 3'd1, 3'd3, 1'b0};
        vecs[2]  = '{32'h0000_0001, 1'b0, 1'b1, 3'd2, 3'd2, 1'b0};
        vecs[3]  = '{32'h7FC0_0000, 1'b0, 1'b0, 3'd3, 3'd4, 1'b0};
        vecs[4]  = '{32'h7F80_0001, 1'b0, 1'b0, 3'd4, 3'd5, 1'b0};
        vecs[5]  = '{32'h8000_0000, 1'b0, 1'b0, 3'd5, 3'd1, 1'b0};
        vecs[6]  = '{32'hFF80_0000, 1'b0, 1'b0, 3'd6, 3'd3, 1'b0};
        vecs[7]  = '{32'h0000_0000, 1'b1, 1'b0, 3'd0, 3'd1, 1'b1};
        vecs[8]  = '{32'h7F80_0000, 1'b0, 1'b1, 3'd0, 3'd3, 1'b1};
        vecs[9]  = '{32'h3F80_0000, 1'b1, 1'b1, 3'd0, 3'd0, 1'b1};
        vecs[10] = '{32'h807F_FFFF, 1'b0, 1'b0, 3'd0, 3'd2, 1'b0};
        vecs[11] = '{32'h7FFF_FFFF, 1'b0, 1'b0, 3'd7, 3'd4, 1'b0};
        vecs[12] = '{32'h7FBF_FFFF, 1'b0, 1'b0, 3'd0, 3'd5, 1'b0};
        vecs[13] = '{32'h0080_0000, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0};
        vecs[14] = '{32'h7F7F_FFFF, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0};

        // T1: single beat through an empty queue
        reset_dut();
        chk("t1_reset_count", 32'(count), 32'd0);
        cycle(1'b1, 32'h3F80_0000, 1'b0, 1'b0, 3'd0, 1'b0);
        chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_out_z", bus.out_z, 32'h3F80_0000);
        chk("t1_class", 32'(bus.out_class), 32'd0);
        chk("t1_count", 32'(count), 32'd1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b1);
        chk("t1_count_after_pop", 32'(count), 32'd0);
        chk("t1_valid_after_pop", 32'(bus.out_valid), 32'd0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b1);
        chk("t1_pop_empty_count", 32'(count), 32'd0);

        // Table: classification and flag-consistency per beat
        for (int i = 0; i < 15; i++) begin
            reset_dut();
            cycle(1'b1, vecs[i].z, vecs[i].ov, vecs[i].ud, vecs[i].rm, 1'b0);
            chk($sformatf("vec%0d_class", i), 32'(bus.out_class), 32'(vecs[i].exp_class));
            chk($sformatf("vec%0d_err", i), 32'(flag_err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_rmode", i), 32'(bus.out_rmode), 32'(vecs[i].rm));
            cycle(1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b1);
        end

        // T2: mixed classes in order, flag counters
        reset_dut();
        cycle(1'b1, 32'h7F80_0000, 1'b1, 1'b0, 3'd0, 1'b0);
        cycle(1'b1, 32'h0000_0001, 1'b0, 1'b1, 3'd0, 1'b0);
        cycle(1'b1, 32'h7FC0_0000, 1'b0, 1'b0, 3'd0, 1'b0);
        cycle(1'b1, 32'h7F80_0001, 1'b0, 1'b0, 3'd0, 1'b0);
        cycle(1'b1, 32'h8000_0000, 1'b0, 1'b0, 3'd0, 1'b0);
        chk("t2_ovf", 32'(ovf_cnt), 32'd1);
        chk("t2_udf", 32'(udf_cnt), 32'd1);
        chk("t2_err", 32'(flag_err), 32'd0);
        begin
            logic [2:0] exp_cls[5];
            exp_cls = '{3'd3, 3'd2, 3'd4, 3'd5, 3'd1};
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("t2_class%0d", i), 32'(bus.out_class), 32'(exp_cls[i]));
                cycle(1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b1);
            end
        end

        // T3: fill to full, ninth beat refused, drain in order
        reset_dut();
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'h10 + 32'(i), 1'b0, 1'b0, 3'(i), 1'b0);
        chk("t3_full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("t3_full_count", 32'(count), 32'd8);
        cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 3'd0, 1'b0);
        chk("t3_ninth_ignored_ovf", 32'(ovf_cnt), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t3_drain%0d", i), bus.out_z, 32'h10 + 32'(i));
            cycle(1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b1);
        end

        // T4: steady push+pop at count=4 across pointer wrap
        reset_dut();
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h4000_0000 + 32'(i), 1'b0, 1'b0, 3'd1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("t4_head%0d", i), bus.out_z, 32'h4000_0000 + 32'(i));
            cycle(1'b1, 32'h4000_0004 + 32'(i), 1'b0, 1'b0, 3'd2, 1'b1);
            chk($sformatf("t4_count%0d", i), 32'(count), 32'd4);
        end

        // T5: sticky flag_err, cleared only by reset
        reset_dut();
        cycle(1'b1, 32'h0000_0000, 1'b1, 1'b0, 3'd0, 1'b0);
        chk("t5_err_set", 32'(flag_err), 32'd1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h3F80_0000, 1'b0, 1'b0, 3'd0, 1'b1);
        chk("t5_err_sticky", 32'(flag_err), 32'd1);
        reset_dut();
        chk("t5_err_cleared", 32'(flag_err), 32'd0);

        // Randomized traffic against the model, with one mid-stream reset
        for (int i = 0; i < 600; i++) begin
            if (i == 300) reset_dut();
            cycle(1'($urandom_range(0, 99) < 60), rand_z(), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 99) < 50));
        end

        // T6: narrow counter saturates, reset with entries flushes
        @(posedge clk); #1;
        rst2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus2.in_valid = 1'b1; bus2.fp_Z = 32'h7F80_0000; bus2.ovrf = 1'b1;
            @(posedge clk); #1;
        end
        bus2.in_valid = 1'b0; bus2.ovrf = 1'b0;
        chk("t6_count", 32'(count2), 32'd5);
        chk("t6_ovf_sat", 32'(ovf_cnt2), 32'd3);
        chk("t6_udf", 32'(udf_cnt2), 32'd0);
        rst2 = 1'b1;
        @(posedge clk); #1;
        rst2 = 1'b0;
        chk("t6_rst_count", 32'(count2), 32'd0);
        chk("t6_rst_valid", 32'(bus2.out_valid), 32'd0);
        chk("t6_rst_ovf", 32'(ovf_cnt2), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
